// File: rtl/mult_iter_unit_if.sv
// mult_iter_unit_if: request/result bundle between the multiply-stage latch,
// the iterative multiplier and the writeback latch.
interface mult_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] operand_A;
    logic [WIDTH-1:0] operand_B;
    logic [31:0]      reg_input;
    logic [31:0]      ins_input;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic [31:0]      reg_output;
    logic [31:0]      ins_output;

    modport master (
        output start, flush, operand_A, operand_B,
        output reg_input, ins_input,
        input  busy, result_valid, result, overflow,
        input  reg_output, ins_output
    );

    modport slave (
        input  start, flush, operand_A, operand_B,
        input  reg_input, ins_input,
        output busy, result_valid, result, overflow,
        output reg_output, ins_output
    );
endinterface

// File: rtl/mult_iter_unit.sv
// mult_iter_unit: iterative signed Booth multiplier, tag/instruction carried.
// Define MULT_RADIX4_EN for radix-4 Booth (WIDTH/2 steps instead of WIDTH).
module mult_iter_unit #(
    parameter int WIDTH = 32
) (
    input logic             clock,
    input logic             reset_n,
    mult_iter_unit_if.slave bus
);
`ifdef MULT_RADIX4_EN
    localparam int NSTEP = WIDTH / 2;
    localparam int SH    = 2;
`else
    localparam int NSTEP = WIDTH;
    localparam int SH    = 1;
`endif
    localparam int CW = $clog2(NSTEP + 1);
    // Two guard bits keep +/-2M and -(-2^(W-1)) exact in the upper half.
    localparam int HW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic signed [HW-1:0]    r_acc;
    logic [WIDTH-1:0]        r_mq;
    logic                    r_qm1;
    logic [WIDTH-1:0]        r_mcand;
    logic [31:0]             r_tag;
    logic [31:0]             r_ins;
    logic [CW-1:0]           r_cnt;
    logic                    r_busy;
    logic                    r_valid;
    logic [WIDTH-1:0]        r_result;
    logic                    r_ovf;
    logic [31:0]             r_reg_out;
    logic [31:0]             r_ins_out;

    logic signed [HW-1:0]    w_m;
    logic signed [HW-1:0]    w_addend;
    logic signed [HW-1:0]    w_sum;
    logic signed [HW-1:0]    w_shift;
    logic [WIDTH-1:0]        w_mq_next;
    logic                    w_qm1_next;
    logic [2*WIDTH-1:0]      w_prod;
    logic [WIDTH:0]          w_top;
    logic                    w_ovf;
    logic                    w_last;

    assign w_m = {{2{r_mcand[WIDTH-1]}}, r_mcand};

    always_comb begin
        w_addend = '0;
`ifdef MULT_RADIX4_EN
        case ({r_mq[1:0], r_qm1})
            3'b001, 3'b010: w_addend = w_m;
            3'b011:         w_addend = w_m <<< 1;
            3'b100:         w_addend = -(w_m <<< 1);
            3'b101, 3'b110: w_addend = -w_m;
            default:        w_addend = '0;
        endcase
`else
        case ({r_mq[0], r_qm1})
            2'b01:   w_addend = w_m;
            2'b10:   w_addend = -w_m;
            default: w_addend = '0;
        endcase
`endif
    end

    assign w_sum      = r_acc + w_addend;
    assign w_shift    = w_sum >>> SH;
    assign w_mq_next  = {w_sum[SH-1:0], r_mq[WIDTH-1:SH]};
    assign w_qm1_next = r_mq[SH-1];
    assign w_prod     = {w_shift[WIDTH-1:0], w_mq_next};
    assign w_top      = w_prod[2*WIDTH-1:WIDTH-1];
    assign w_ovf      = (|w_top) && !(&w_top);
    assign w_last     = (r_cnt == CW'(NSTEP - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mq      <= '0;
            r_qm1     <= 1'b0;
            r_mcand   <= '0;
            r_tag     <= '0;
            r_ins     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_reg_out <= '0;
            r_ins_out <= '0;
        end else if (bus.flush) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_reg_out <= '0;
            r_ins_out <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_valid <= 1'b0;
                    if (bus.start) begin
                        r_mcand <= bus.operand_A;
                        r_mq    <= bus.operand_B;
                        r_qm1   <= 1'b0;
                        r_tag   <= bus.reg_input;
                        r_ins   <= bus.ins_input;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= w_shift;
                    r_mq  <= w_mq_next;
                    r_qm1 <= w_qm1_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_valid   <= 1'b1;
                        r_result  <= w_prod[WIDTH-1:0];
                        r_ovf     <= w_ovf;
                        r_reg_out <= r_tag;
                        r_ins_out <= r_ins;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.result_valid = r_valid;
    assign bus.result       = r_result;
    assign bus.overflow     = r_ovf;
    assign bus.reg_output   = r_reg_out;
    assign bus.ins_output   = r_ins_out;
endmodule

// File: tb/tb_mult_iter_unit.sv
// tb_mult_iter_unit: directed checks of mult_iter_unit handshake and products.
module tb_mult_iter_unit;
`ifdef MULT_RADIX4_EN
    localparam int N = 16;
`else
    localparam int N = 32;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   lat;
    int   busy_cyc;

    mult_iter_unit_if #(.WIDTH(32)) bus ();

    mult_iter_unit #(.WIDTH(32)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] tag, input logic [31:0] ins);
        @(negedge clk);
        bus.operand_A = a;
        bus.operand_B = b;
        bus.reg_input = tag;
        bus.ins_input = ins;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!bus.result_valid && lat < 60) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.flush = 0;
        bus.operand_A = 0; bus.operand_B = 0;
        bus.reg_input = 0; bus.ins_input = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.result_valid, bus.overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000",
                     {bus.busy, bus.result_valid, bus.overflow});
        end
        checks++;
        if ({bus.result, bus.reg_output, bus.ins_output} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0",
                     {bus.result, bus.reg_output, bus.ins_output});
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        run_mul(32'd7, 32'd6, 32'd5, 32'h00A00000);
        checks++;
        if (lat !== N) begin
            errors++;
            $display("FAIL basic_latency: got %0d required %0d", lat, N);
        end
        checks++;
        if (busy_cyc !== N) begin
            errors++;
            $display("FAIL basic_busy: got %0d required %0d", busy_cyc, N);
        end
        checks++;
        if ({bus.result, bus.overflow, bus.busy} !== {32'd42, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got %h/%b/%b required 0000002a/0/0",
                     bus.result, bus.overflow, bus.busy);
        end
        checks++;
        if ({bus.reg_output, bus.ins_output} !== {32'd5, 32'h00A00000}) begin
            errors++;
            $display("FAIL basic_tags: got %h %h required 00000005 00a00000",
                     bus.reg_output, bus.ins_output);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.result_valid, bus.result} !== {1'b0, 32'd42}) begin
            errors++;
            $display("FAIL basic_hold: got %b/%h required 0/0000002a",
                     bus.result_valid, bus.result);
        end
    endtask

    task automatic test_products();
        logic [31:0] va [8] = '{32'hFFFFFFFD, 32'h00010000, 32'h80000000,
                                32'hFFFFFFFB, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'hFFFFFFF9};
        logic [31:0] vb [8] = '{32'h7FFFFFFF, 32'h00010000, 32'hFFFFFFFF,
                                32'hFFFFFFFB, 32'h7FFFFFFF, 32'h80000000,
                                32'h00000001, 32'h00000006};
        logic [31:0] vr [8] = '{32'h80000003, 32'h00000000, 32'h80000000,
                                32'h00000019, 32'h00000001, 32'h80000000,
                                32'h80000000, 32'hFFFFFFD6};
        logic        vo [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_mul(va[i], vb[i], 32'(i + 100), 32'h1000 + 32'(i));
            checks++;
            if ({lat, bus.result, bus.overflow, bus.reg_output} !==
                {N, vr[i], vo[i], 32'(i + 100)}) begin
                errors++;
                $display("FAIL product_%0d: got lat=%0d %h ovf=%b tag=%0d required lat=%0d %h ovf=%b tag=%0d",
                         i, lat, bus.result, bus.overflow, bus.reg_output,
                         N, vr[i], vo[i], i + 100);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        run_mul(32'd10, 32'd11, 32'd1, 32'h11);
        checks++;
        if ({bus.result_valid, bus.result} !== {1'b1, 32'd110}) begin
            errors++;
            $display("FAIL b2b_first: got %b/%h required 1/0000006e",
                     bus.result_valid, bus.result);
        end
        bus.operand_A = 32'd2;
        bus.operand_B = 32'd3;
        bus.reg_input = 32'd2;
        bus.ins_input = 32'h22;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        gap = 1;
        checks++;
        if ({bus.busy, bus.result_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_capture: got busy/valid %b required 10",
                     {bus.busy, bus.result_valid});
        end
        while (!bus.result_valid && gap < 60) begin
            @(posedge clk);
            #1;
            gap++;
        end
        checks++;
        if (gap !== N + 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d required %0d", gap, N + 1);
        end
        checks++;
        if ({bus.result, bus.reg_output} !== {32'd6, 32'd2}) begin
            errors++;
            $display("FAIL b2b_second: got %h tag %0d required 00000006 tag 2",
                     bus.result, bus.reg_output);
        end
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        bus.operand_A = 32'd123;
        bus.operand_B = 32'd4;
        bus.reg_input = 32'd9;
        bus.ins_input = 32'h99;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.start     = 1'b1;
        bus.operand_A = 32'd3;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.result_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush_busy: got busy/valid %b required 00",
                     {bus.busy, bus.result_valid});
        end
        checks++;
        if ({bus.reg_output, bus.ins_output, bus.result, bus.overflow} !== 97'h0) begin
            errors++;
            $display("FAIL flush_clear: got %h %h %h %b required all 0",
                     bus.reg_output, bus.ins_output, bus.result, bus.overflow);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_quiet: got %0d active cycles required 0", seen);
        end
        run_mul(32'd9, 32'hFFFFFFFC, 32'd7, 32'h77);
        checks++;
        if ({lat, bus.result, bus.reg_output} !== {N, 32'hFFFFFFDC, 32'd7}) begin
            errors++;
            $display("FAIL flush_after: got lat=%0d %h tag %0d required lat=%0d ffffffdc tag 7",
                     lat, bus.result, bus.reg_output, N);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.operand_A = 32'd5;
        bus.operand_B = 32'd5;
        bus.reg_input = 32'd3;
        bus.ins_input = 32'h33;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({bus.busy, bus.result_valid, bus.overflow, bus.result,
             bus.reg_output, bus.ins_output} !== 99'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b res=%h tag=%h ins=%h required all 0",
                     bus.busy, bus.result, bus.reg_output, bus.ins_output);
        end
        @(negedge clk);
        rst_n = 1;
        run_mul(32'd7, 32'd6, 32'd5, 32'h00A00000);
        checks++;
        if ({lat, bus.result, bus.overflow, bus.reg_output} !==
            {N, 32'd42, 1'b0, 32'd5}) begin
            errors++;
            $display("FAIL reset_recover: got lat=%0d %h ovf=%b tag=%0d required lat=%0d 0000002a 0 5",
                     lat, bus.result, bus.overflow, bus.reg_output, N);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_products();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
